// File: rtl/bus_arbiter_rr2.sv
// bus_arbiter_rr2: two-master to one-slave arbiter for the req/ack/resp bus.
// Latency: zero cycles; request -> slave and response -> master are purely combinational.
// Backpressure: the slave stall (s_ack_i=0) locks the grant; a read is held off while the ID FIFO is full.
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   m0_* / m1_*                     master request (req/we/addr/be/wdata in), ack/resp/rdata out
//   s_*                             slave request out, s_ack_i / s_resp_i / s_rdata_bi in
//
// Optional feature: define BUS_ARB_FIXED_PRIO_EN to make master 0 always win
// simultaneous requests (no round-robin priority register). The grant lock
// still applies, so a stalled master 1 transfer finishes before master 0 is served.

module bus_arbiter_rr2 #(
   parameter int RESP_DEPTH = 4,   // max outstanding reads, power of two, >= 2
   parameter int RESP_AW    = 2    // log2(RESP_DEPTH)
) (
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic        m0_req_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_addr_bi,
   input  logic [3:0]  m0_be_bi,
   input  logic [31:0] m0_wdata_bi,
   output logic        m0_ack_o,
   output logic        m0_resp_o,
   output logic [31:0] m0_rdata_bo,

   input  logic        m1_req_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_addr_bi,
   input  logic [3:0]  m1_be_bi,
   input  logic [31:0] m1_wdata_bi,
   output logic        m1_ack_o,
   output logic        m1_resp_o,
   output logic [31:0] m1_rdata_bo,

   output logic        s_req_o,
   output logic        s_we_o,
   output logic [31:0] s_addr_bo,
   output logic [3:0]  s_be_bo,
   output logic [31:0] s_wdata_bo,
   input  logic        s_ack_i,
   input  logic        s_resp_i,
   input  logic [31:0] s_rdata_bi
);

   localparam logic [RESP_AW:0] FULL_CNT = (RESP_AW+1)'(RESP_DEPTH);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } lock_st_t;

   lock_st_t               r_lock_st;
   logic                   r_lock_id;
`ifndef BUS_ARB_FIXED_PRIO_EN
   logic                   r_prio;
`endif

   // ID FIFO: one bit per outstanding read, naming the master that issued it
   logic [RESP_DEPTH-1:0]  r_id_mem;
   logic [RESP_AW-1:0]     r_wr_ptr;
   logic [RESP_AW-1:0]     r_rd_ptr;
   logic [RESP_AW:0]       r_count;

   logic                   w_prio;
   logic                   w_gnt_vld;
   logic                   w_gnt_id;
   logic                   w_g_req;
   logic                   w_g_we;
   logic                   w_fifo_full;
   logic                   w_blocked;
   logic                   w_xfer;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_head;

`ifdef BUS_ARB_FIXED_PRIO_EN
   assign w_prio = 1'b0;
`else
   assign w_prio = r_prio;
`endif

   // Grant: a held lock overrides everything, else single requester, else priority
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_id  = 1'b0;
      if (r_lock_st == ST_LOCKED) begin
         w_gnt_vld = 1'b1;
         w_gnt_id  = r_lock_id;
      end else if (m0_req_i && m1_req_i) begin
         w_gnt_vld = 1'b1;
         w_gnt_id  = w_prio;
      end else if (m0_req_i) begin
         w_gnt_vld = 1'b1;
         w_gnt_id  = 1'b0;
      end else if (m1_req_i) begin
         w_gnt_vld = 1'b1;
         w_gnt_id  = 1'b1;
      end
   end

   assign w_g_req     = w_gnt_id ? m1_req_i : m0_req_i;
   assign w_g_we      = w_gnt_id ? m1_we_i  : m0_we_i;
   assign w_fifo_full = (r_count == FULL_CNT);

   // Full check uses the registered count only: a pop in this cycle does not
   // free the slot until the next cycle, keeping the path free of s_resp_i.
   assign w_blocked = w_gnt_vld & w_g_req & ~w_g_we & w_fifo_full;

   assign s_req_o    = w_gnt_vld & w_g_req & ~w_blocked;
   assign s_we_o     = w_gnt_vld & w_g_we;
   assign s_addr_bo  = !w_gnt_vld ? 32'h0 : (w_gnt_id ? m1_addr_bi  : m0_addr_bi);
   assign s_be_bo    = !w_gnt_vld ? 4'h0  : (w_gnt_id ? m1_be_bi    : m0_be_bi);
   assign s_wdata_bo = !w_gnt_vld ? 32'h0 : (w_gnt_id ? m1_wdata_bi : m0_wdata_bi);

   assign w_xfer   = s_req_o & s_ack_i;
   assign m0_ack_o = w_xfer & ~w_gnt_id;
   assign m1_ack_o = w_xfer &  w_gnt_id;

   assign w_push = w_xfer & ~w_g_we;
   // Responses arriving with nothing outstanding are dropped
   assign w_pop  = s_resp_i & (r_count != '0);
   assign w_head = r_id_mem[r_rd_ptr];

   assign m0_resp_o   = w_pop & ~w_head;
   assign m1_resp_o   = w_pop &  w_head;
   assign m0_rdata_bo = s_rdata_bi;
   assign m1_rdata_bo = s_rdata_bi;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_lock_st <= ST_IDLE;
         r_lock_id <= 1'b0;
`ifndef BUS_ARB_FIXED_PRIO_EN
         r_prio    <= 1'b0;
`endif
         r_id_mem  <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
      end else begin
         // A blocked read also takes the lock so the other master cannot slip past it
         case (r_lock_st)
            ST_IDLE: begin
               if ((s_req_o && !s_ack_i) || w_blocked) begin
                  r_lock_st <= ST_LOCKED;
                  r_lock_id <= w_gnt_id;
               end
            end
            ST_LOCKED: begin
               if (w_xfer) begin
                  r_lock_st <= ST_IDLE;
               end
            end
            default: r_lock_st <= ST_IDLE;
         endcase

`ifndef BUS_ARB_FIXED_PRIO_EN
         if (w_xfer) begin
            r_prio <= ~w_gnt_id;
         end
`endif

         if (w_push) begin
            r_id_mem[r_wr_ptr] <= w_gnt_id;
            r_wr_ptr           <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_arbiter_rr2.sv
// tb_bus_arbiter_rr2: directed bench for bus_arbiter_rr2 with hand-computed expectations.
// Inputs change on the falling edge; combinational outputs are sampled 1 ns later.
// The bench plays both masters and the slave; it never waits on a DUT event.

module tb_bus_arbiter_rr2;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
   logic [31:0] m0_addr_bi, m0_wdata_bi, m1_addr_bi, m1_wdata_bi;
   logic [3:0]  m0_be_bi, m1_be_bi;
   logic        m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
   logic [31:0] m0_rdata_bo, m1_rdata_bo;
   logic        s_req_o, s_we_o, s_ack_i, s_resp_i;
   logic [31:0] s_addr_bo, s_wdata_bo, s_rdata_bi;
   logic [3:0]  s_be_bo;

   int n_checks = 0;
   int n_errors = 0;

`ifdef BUS_ARB_FIXED_PRIO_EN
   localparam bit FIXED_PRIO = 1'b1;
`else
   localparam bit FIXED_PRIO = 1'b0;
`endif

   always #5 clk_i = ~clk_i;

   bus_arbiter_rr2 #(.RESP_DEPTH(4), .RESP_AW(2)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .m0_req_i    (m0_req_i),
      .m0_we_i     (m0_we_i),
      .m0_addr_bi  (m0_addr_bi),
      .m0_be_bi    (m0_be_bi),
      .m0_wdata_bi (m0_wdata_bi),
      .m0_ack_o    (m0_ack_o),
      .m0_resp_o   (m0_resp_o),
      .m0_rdata_bo (m0_rdata_bo),
      .m1_req_i    (m1_req_i),
      .m1_we_i     (m1_we_i),
      .m1_addr_bi  (m1_addr_bi),
      .m1_be_bi    (m1_be_bi),
      .m1_wdata_bi (m1_wdata_bi),
      .m1_ack_o    (m1_ack_o),
      .m1_resp_o   (m1_resp_o),
      .m1_rdata_bo (m1_rdata_bo),
      .s_req_o     (s_req_o),
      .s_we_o      (s_we_o),
      .s_addr_bo   (s_addr_bo),
      .s_be_bo     (s_be_bo),
      .s_wdata_bo  (s_wdata_bo),
      .s_ack_i     (s_ack_i),
      .s_resp_i    (s_resp_i),
      .s_rdata_bi  (s_rdata_bi)
   );

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_m0(input logic req, input logic we, input logic [31:0] addr);
      m0_req_i = req; m0_we_i = we; m0_addr_bi = addr;
   endtask

   task automatic set_m1(input logic req, input logic we, input logic [31:0] addr);
      m1_req_i = req; m1_we_i = we; m1_addr_bi = addr;
   endtask

   task automatic chk_all_zero(input string tag);
      chk_eq({tag, "_s_req"},   {31'b0, s_req_o}, 32'h0);
      chk_eq({tag, "_s_we"},    {31'b0, s_we_o}, 32'h0);
      chk_eq({tag, "_s_addr"},  s_addr_bo, 32'h0);
      chk_eq({tag, "_s_be"},    {28'b0, s_be_bi_view()}, 32'h0);
      chk_eq({tag, "_s_wdata"}, s_wdata_bo, 32'h0);
      chk_eq({tag, "_acks"},    {30'b0, m0_ack_o, m1_ack_o}, 32'h0);
      chk_eq({tag, "_resps"},   {30'b0, m0_resp_o, m1_resp_o}, 32'h0);
   endtask

   function automatic logic [3:0] s_be_bi_view();
      return s_be_bo;
   endfunction

   initial begin
      rst_i = 1'b1;
      set_m0(1'b0, 1'b0, 32'h0); set_m1(1'b0, 1'b0, 32'h0);
      m0_be_bi = 4'hF; m0_wdata_bi = 32'h0; m1_be_bi = 4'hF; m1_wdata_bi = 32'h0;
      s_ack_i = 1'b0; s_resp_i = 1'b0; s_rdata_bi = 32'h0;

      // Reset state
      repeat (2) @(negedge clk_i);
      #1 chk_all_zero("rst");
      @(negedge clk_i); rst_i = 1'b0;
      // Inputs idle, so all bus outputs are zero apart from the rdata passthrough
      m0_be_bi = 4'h0; m1_be_bi = 4'h0;
      #1 chk_all_zero("idle");
      m0_be_bi = 4'hF; m1_be_bi = 4'hF;

      // T1: simultaneous reads, prio=0 -> m0 first, then m1; responses in order
      @(negedge clk_i);
      s_ack_i = 1'b1; set_m0(1'b1, 1'b0, 32'h100); set_m1(1'b1, 1'b0, 32'h200);
      #1 chk_eq("t1_c0_m0_ack", {31'b0, m0_ack_o}, 32'h1);
      chk_eq("t1_c0_m1_ack", {31'b0, m1_ack_o}, 32'h0);
      chk_eq("t1_c0_addr", s_addr_bo, 32'h100);
      @(negedge clk_i); m0_req_i = 1'b0;
      #1 chk_eq("t1_c1_m1_ack", {31'b0, m1_ack_o}, 32'h1);
      chk_eq("t1_c1_m0_ack", {31'b0, m0_ack_o}, 32'h0);
      chk_eq("t1_c1_addr", s_addr_bo, 32'h200);
      @(negedge clk_i); m1_req_i = 1'b0; s_ack_i = 1'b0;
      s_resp_i = 1'b1; s_rdata_bi = 32'hAAAA_0000;
      #1 chk_eq("t1_r0_m0_resp", {31'b0, m0_resp_o}, 32'h1);
      chk_eq("t1_r0_m1_resp", {31'b0, m1_resp_o}, 32'h0);
      chk_eq("t1_r0_m0_rdata", m0_rdata_bo, 32'hAAAA_0000);
      @(negedge clk_i); s_rdata_bi = 32'hBBBB_0000;
      #1 chk_eq("t1_r1_m1_resp", {31'b0, m1_resp_o}, 32'h1);
      chk_eq("t1_r1_m0_resp", {31'b0, m0_resp_o}, 32'h0);
      chk_eq("t1_r1_m1_rdata", m1_rdata_bo, 32'hBBBB_0000);
      @(negedge clk_i); s_resp_i = 1'b0;

      // T2: an m0 write first moves priority to m1
      s_ack_i = 1'b1; set_m0(1'b1, 1'b1, 32'h40);
      #1 chk_eq("t2_pre_m0_ack", {31'b0, m0_ack_o}, 32'h1);
      // m1 write stalled three cycles while m0 requests a read throughout
      @(negedge clk_i);
      s_ack_i = 1'b0; set_m0(1'b1, 1'b0, 32'h300);
      set_m1(1'b1, 1'b1, 32'h8000_0000); m1_wdata_bi = 32'hCAFE_F00D; m1_be_bi = 4'h3;
      #1 chk_eq("t2_s0_req", {31'b0, s_req_o}, 32'h1);
      chk_eq("t2_s0_we", {31'b0, s_we_o}, 32'h1);
      chk_eq("t2_s0_addr", s_addr_bo, 32'h8000_0000);
      chk_eq("t2_s0_acks", {30'b0, m0_ack_o, m1_ack_o}, 32'h0);
      for (int i = 1; i < 3; i++) begin
         @(negedge clk_i);
         #1 chk_eq("t2_stall_addr", s_addr_bo, 32'h8000_0000);
         chk_eq("t2_stall_acks", {30'b0, m0_ack_o, m1_ack_o}, 32'h0);
      end
      @(negedge clk_i); s_ack_i = 1'b1;
      #1 chk_eq("t2_c3_m1_ack", {31'b0, m1_ack_o}, 32'h1);
      chk_eq("t2_c3_m0_ack", {31'b0, m0_ack_o}, 32'h0);
      chk_eq("t2_c3_wdata", s_wdata_bo, 32'hCAFE_F00D);
      chk_eq("t2_c3_be", {28'b0, s_be_bo}, 32'h3);
      @(negedge clk_i); m1_req_i = 1'b0; m1_be_bi = 4'hF;
      #1 chk_eq("t2_c4_m0_ack", {31'b0, m0_ack_o}, 32'h1);
      chk_eq("t2_c4_addr", s_addr_bo, 32'h300);
      chk_eq("t2_c4_we", {31'b0, s_we_o}, 32'h0);
      @(negedge clk_i); m0_req_i = 1'b0; s_resp_i = 1'b1; s_rdata_bi = 32'h1234_5678;
      #1 chk_eq("t2_resp_m0", {31'b0, m0_resp_o}, 32'h1);
      @(negedge clk_i); s_resp_i = 1'b0;

      // T3: four m0 reads fill the FIFO
      for (int i = 0; i < 4; i++) begin
         set_m0(1'b1, 1'b0, 32'h1000 + 32'(4 * i));
         #1 chk_eq("t3_fill_ack", {31'b0, m0_ack_o}, 32'h1);
         @(negedge clk_i);
      end
      // m1 write accepted while full
      m0_req_i = 1'b0; set_m1(1'b1, 1'b1, 32'h2000);
      #1 chk_eq("t3_full_wr_ack", {31'b0, m1_ack_o}, 32'h1);
      chk_eq("t3_full_wr_we", {31'b0, s_we_o}, 32'h1);
      // fifth read blocked
      @(negedge clk_i); m1_req_i = 1'b0; set_m0(1'b1, 1'b0, 32'h1010);
      #1 chk_eq("t3_blk_s_req", {31'b0, s_req_o}, 32'h0);
      chk_eq("t3_blk_m0_ack", {31'b0, m0_ack_o}, 32'h0);
      // pop this cycle: still blocked, and m1 cannot bypass the lock
      @(negedge clk_i); set_m1(1'b1, 1'b0, 32'h3000);
      s_resp_i = 1'b1; s_rdata_bi = 32'h0000_00D0;
      #1 chk_eq("t3_pop_s_req", {31'b0, s_req_o}, 32'h0);
      chk_eq("t3_pop_acks", {30'b0, m0_ack_o, m1_ack_o}, 32'h0);
      chk_eq("t3_pop_m0_resp", {31'b0, m0_resp_o}, 32'h1);
      // slot freed: fifth read acked
      @(negedge clk_i); s_resp_i = 1'b0;
      #1 chk_eq("t3_5th_m0_ack", {31'b0, m0_ack_o}, 32'h1);
      chk_eq("t3_5th_m1_ack", {31'b0, m1_ack_o}, 32'h0);
      chk_eq("t3_5th_addr", s_addr_bo, 32'h1010);
      // FIFO full again, m1 read blocked while the head response drains
      @(negedge clk_i); m0_req_i = 1'b0; s_resp_i = 1'b1;
      #1 chk_eq("t3_d1_m1_ack", {31'b0, m1_ack_o}, 32'h0);
      chk_eq("t3_d1_m0_resp", {31'b0, m0_resp_o}, 32'h1);
      @(negedge clk_i);
      #1 chk_eq("t3_d2_m1_ack", {31'b0, m1_ack_o}, 32'h1);
      chk_eq("t3_d2_m0_resp", {31'b0, m0_resp_o}, 32'h1);
      @(negedge clk_i); m1_req_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1 chk_eq("t3_drain_m0_resp", {31'b0, m0_resp_o}, 32'h1);
         chk_eq("t3_drain_m1_resp", {31'b0, m1_resp_o}, 32'h0);
         @(negedge clk_i);
      end
      #1 chk_eq("t3_last_m1_resp", {31'b0, m1_resp_o}, 32'h1);
      chk_eq("t3_last_m0_resp", {31'b0, m0_resp_o}, 32'h0);

      // T4: response with empty FIFO is dropped
      @(negedge clk_i); s_rdata_bi = 32'h0000_00EE;
      #1 chk_eq("t4_empty_resps", {30'b0, m0_resp_o, m1_resp_o}, 32'h0);
      @(negedge clk_i); s_resp_i = 1'b0; set_m1(1'b1, 1'b0, 32'h500);
      #1 chk_eq("t4_rd_m1_ack", {31'b0, m1_ack_o}, 32'h1);
      @(negedge clk_i); m1_req_i = 1'b0; s_resp_i = 1'b1; s_rdata_bi = 32'h55;
      #1 chk_eq("t4_after_m1_resp", {31'b0, m1_resp_o}, 32'h1);
      chk_eq("t4_after_m0_resp", {31'b0, m0_resp_o}, 32'h0);

      // T5: reset with two reads outstanding and prio=1
      @(negedge clk_i); s_resp_i = 1'b0; set_m1(1'b1, 1'b0, 32'h600);
      #1 chk_eq("t5_m1_ack", {31'b0, m1_ack_o}, 32'h1);
      @(negedge clk_i); m1_req_i = 1'b0; set_m0(1'b1, 1'b0, 32'h700);
      #1 chk_eq("t5_m0_ack", {31'b0, m0_ack_o}, 32'h1);
      @(negedge clk_i); m0_req_i = 1'b0; s_ack_i = 1'b0; rst_i = 1'b1;
      @(negedge clk_i); rst_i = 1'b0;
      #1 chk_eq("t5_post_s_req", {31'b0, s_req_o}, 32'h0);
      @(negedge clk_i); s_resp_i = 1'b1; s_rdata_bi = 32'h77;
      #1 chk_eq("t5_stale_resps", {30'b0, m0_resp_o, m1_resp_o}, 32'h0);
      @(negedge clk_i); s_resp_i = 1'b0; s_ack_i = 1'b1;
      set_m0(1'b1, 1'b0, 32'h800); set_m1(1'b1, 1'b0, 32'h900);
      #1 chk_eq("t5_both_m0_ack", {31'b0, m0_ack_o}, 32'h1);
      chk_eq("t5_both_m1_ack", {31'b0, m1_ack_o}, 32'h0);
      chk_eq("t5_both_addr", s_addr_bo, 32'h800);

      // T6: both write continuously; prio is 1 after the m0 read above
      @(negedge clk_i);
      set_m0(1'b1, 1'b1, 32'hA0); set_m1(1'b1, 1'b1, 32'hB0);
      for (int i = 0; i < 4; i++) begin
         #1 chk_eq("t6_m1_ack", {31'b0, m1_ack_o},
                   FIXED_PRIO ? 32'h0 : ((i % 2 == 0) ? 32'h1 : 32'h0));
         chk_eq("t6_m0_ack", {31'b0, m0_ack_o},
                FIXED_PRIO ? 32'h1 : ((i % 2 == 0) ? 32'h0 : 32'h1));
         @(negedge clk_i);
      end
      m0_req_i = 1'b0; m1_req_i = 1'b0; s_ack_i = 1'b0;
      @(negedge clk_i);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
